// File: rtl/bidir_pad_ctrl_pkg.sv
// Shared types and constants for the bidir pad bank driver.
// Imported by bidir_pad_ctrl and bidir_in_sync.
package bidir_pad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRIVE    = 2'd1,
        TURN_OFF = 2'd2,
        SETTLE   = 2'd3
    } state_t;

    localparam int unsigned SETTLE_CYCLES = 2;
    localparam int unsigned SYNC_STAGES   = 2;

endpackage

// File: rtl/bidir_pad_ctrl_in_sync.sv
// N-wide multi-flop synchroniser for the pad Y inputs.
// Asynchronous active-low reset clears every stage to 0.
module bidir_in_sync
    import bidir_pad_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/bidir_pad_ctrl.sv
// Core-side driver for the bi_24t pad bank: tx handshake, OE turnaround, rx change detect.
// Optional BIDIR_PAD_CTRL_READBACK_EN adds a sticky drive_err readback comparator.
`ifndef NUM_BIDIR_PADS
`define NUM_BIDIR_PADS 8
`endif

module bidir_pad_ctrl
    import bidir_pad_pkg::*;
#(
    parameter int unsigned NUM_BIDIR_PADS = `NUM_BIDIR_PADS,
    parameter int unsigned HOLD_W         = 8,
    parameter int unsigned TURN_CYCLES    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    input  logic [NUM_BIDIR_PADS-1:0] tx_data,
    input  logic                      tx_last,
    input  logic [HOLD_W-1:0]         cfg_hold,
    input  logic [NUM_BIDIR_PADS-1:0] cfg_cs,
    input  logic [NUM_BIDIR_PADS-1:0] cfg_sl,
    input  logic [NUM_BIDIR_PADS-1:0] cfg_pu,
    input  logic [NUM_BIDIR_PADS-1:0] cfg_pd,
    output logic                      rx_valid,
    output logic [NUM_BIDIR_PADS-1:0] rx_data,
    output logic                      busy,
    input  logic [NUM_BIDIR_PADS-1:0] bidir_in,
    output logic [NUM_BIDIR_PADS-1:0] bidir_out,
    output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
    output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
    output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
    output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
    output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
    output logic [NUM_BIDIR_PADS-1:0] bidir_pd
`ifdef BIDIR_PAD_CTRL_READBACK_EN
    ,
    output logic                      drive_err
`endif
);

    state_t                      state;
    logic [HOLD_W-1:0]           cnt;
    logic                        last_q;
    logic                        out_ready;
    logic                        hold_done;
    logic                        accept;
    logic [HOLD_W-1:0]           hold_load;
    logic [NUM_BIDIR_PADS-1:0]   sync_q;

    // out_ready keeps tx_ready low while reset is asserted even though state is IDLE
    assign hold_done = (state == DRIVE) && (cnt == '0);
    assign tx_ready  = out_ready && ((state == IDLE) || (hold_done && !last_q));
    assign accept    = tx_valid && tx_ready;
    assign hold_load = (cfg_hold == '0) ? '0 : cfg_hold - HOLD_W'(1);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            last_q    <= 1'b0;
            out_ready <= 1'b0;
            bidir_out <= '0;
            bidir_oe  <= '0;
            bidir_ie  <= '1;
        end else begin
            out_ready <= 1'b1;
            if (accept) begin
                state     <= DRIVE;
                cnt       <= hold_load;
                last_q    <= tx_last;
                bidir_out <= tx_data;
                bidir_oe  <= '1;
                bidir_ie  <= '0;
            end else begin
                case (state)
                    DRIVE: begin
                        if (cnt != '0) begin
                            cnt <= cnt - HOLD_W'(1);
                        end else if (last_q) begin
                            bidir_out <= '0;
                            bidir_oe  <= '0;
                            if (TURN_CYCLES == 0) begin
                                state    <= SETTLE;
                                cnt      <= HOLD_W'(SETTLE_CYCLES - 1);
                                bidir_ie <= '1;
                            end else begin
                                state    <= TURN_OFF;
                                cnt      <= HOLD_W'(TURN_CYCLES - 1);
                                bidir_ie <= '0;
                            end
                        end
                        // non-last word with no valid: underrun, keep driving
                    end
                    TURN_OFF: begin
                        if (cnt == '0) begin
                            state    <= SETTLE;
                            cnt      <= HOLD_W'(SETTLE_CYCLES - 1);
                            bidir_ie <= '1;
                        end else begin
                            cnt <= cnt - HOLD_W'(1);
                        end
                    end
                    SETTLE: begin
                        if (cnt == '0) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - HOLD_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    bidir_in_sync #(
        .WIDTH (NUM_BIDIR_PADS)
    ) u_in_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bidir_in),
        .q     (sync_q)
    );

    // rx_data always follows the synchroniser, so leaving the bus produces no stale event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= (state == IDLE) && (sync_q != rx_data);
            rx_data  <= sync_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bidir_cs <= '0;
            bidir_sl <= '0;
            bidir_pu <= '0;
            bidir_pd <= '0;
        end else begin
            bidir_cs <= cfg_cs;
            bidir_sl <= cfg_sl;
            bidir_pu <= cfg_pu;
            bidir_pd <= cfg_pd & ~cfg_pu;
        end
    end

`ifdef BIDIR_PAD_CTRL_READBACK_EN
    logic rb_en_q;

    // short holds give the pad too little time to settle, so they are not checked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_en_q   <= 1'b0;
            drive_err <= 1'b0;
        end else begin
            if (accept) begin
                rb_en_q <= (cfg_hold >= HOLD_W'(3));
            end
            if (hold_done && rb_en_q && (sync_q != bidir_out)) begin
                drive_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bidir_pad_ctrl.sv
// Directed self-checking bench for bidir_pad_ctrl (8 pads, HOLD_W 8, TURN_CYCLES 2).
// Define BIDIR_PAD_CTRL_READBACK_EN to include the drive_err checks.
module tb_bidir_pad_ctrl;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tx_valid;
    logic         tx_ready;
    logic [N-1:0] tx_data;
    logic         tx_last;
    logic [7:0]   cfg_hold;
    logic [N-1:0] cfg_cs, cfg_sl, cfg_pu, cfg_pd;
    logic         rx_valid;
    logic [N-1:0] rx_data;
    logic         busy;
    logic [N-1:0] bidir_in;
    logic [N-1:0] bidir_out, bidir_oe, bidir_ie;
    logic [N-1:0] bidir_cs, bidir_sl, bidir_pu, bidir_pd;
`ifdef BIDIR_PAD_CTRL_READBACK_EN
    logic         drive_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bidir_pad_ctrl #(
        .NUM_BIDIR_PADS (N),
        .HOLD_W         (8),
        .TURN_CYCLES    (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .cfg_hold  (cfg_hold),
        .cfg_cs    (cfg_cs),
        .cfg_sl    (cfg_sl),
        .cfg_pu    (cfg_pu),
        .cfg_pd    (cfg_pd),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .busy      (busy),
        .bidir_in  (bidir_in),
        .bidir_out (bidir_out),
        .bidir_oe  (bidir_oe),
        .bidir_ie  (bidir_ie),
        .bidir_cs  (bidir_cs),
        .bidir_sl  (bidir_sl),
        .bidir_pu  (bidir_pu),
        .bidir_pd  (bidir_pd)
`ifdef BIDIR_PAD_CTRL_READBACK_EN
        ,
        .drive_err (drive_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] words [3];
        words[0] = 8'h11;
        words[1] = 8'h22;
        words[2] = 8'h33;

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        tx_last  = 1'b0;
        cfg_hold = 8'd0;
        cfg_cs   = '0;
        cfg_sl   = '0;
        cfg_pu   = '0;
        cfg_pd   = '0;
        bidir_in = '0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_oe", bidir_oe, 32'h00);
        chk("rst_out", bidir_out, 32'h00);
        chk("rst_ie", bidir_ie, 32'hFF);
        chk("rst_ready", tx_ready, 32'h0);
        chk("rst_busy", busy, 32'h0);
        chk("rst_rxv", rx_valid, 32'h0);
        chk("rst_rxd", rx_data, 32'h00);
        chk("rst_cs", bidir_cs, 32'h00);
        chk("rst_pd", bidir_pd, 32'h00);
`ifdef BIDIR_PAD_CTRL_READBACK_EN
        chk("rst_derr", drive_err, 32'h0);
`endif

        cfg_cs = 8'hA5;
        cfg_sl = 8'h81;
        cfg_pu = 8'h0F;
        cfg_pd = 8'h3C;
        rst_n  = 1'b1;
        tick();
        chk("rel_ready", tx_ready, 32'h1);
        chk("rel_busy", busy, 32'h0);
        chk("rel_oe", bidir_oe, 32'h00);
        chk("rel_ie", bidir_ie, 32'hFF);
        chk("static_cs", bidir_cs, 32'hA5);
        chk("static_sl", bidir_sl, 32'h81);
        chk("static_pu", bidir_pu, 32'h0F);
        chk("static_pd_pu_wins", bidir_pd, 32'h30);

        // rx change in IDLE: pulse 3 edges later
        bidir_in = 8'h5A;
        tick();
        chk("rx_e1", rx_valid, 32'h0);
        tick();
        chk("rx_e2", rx_valid, 32'h0);
        tick();
        chk("rx_e3_valid", rx_valid, 32'h1);
        chk("rx_e3_data", rx_data, 32'h5A);
        tick();
        chk("rx_e4_valid", rx_valid, 32'h0);
        chk("rx_e4_data", rx_data, 32'h5A);

        // back-to-back burst, H=4
        cfg_hold = 8'd4;
        tx_data  = words[0];
        tx_last  = 1'b0;
        tx_valid = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            tick();
            chk("burst_rxv", rx_valid, 32'h0);
            if (c <= 12) begin
                chk("burst_out", bidir_out, 32'(words[(c-1)/4]));
                chk("burst_oe", bidir_oe, 32'hFF);
                chk("burst_ie", bidir_ie, 32'h00);
                chk("burst_ready", tx_ready, (c % 4 == 0 && c < 12) ? 32'h1 : 32'h0);
            end else if (c <= 14) begin
                chk("turn_oe", bidir_oe, 32'h00);
                chk("turn_out", bidir_out, 32'h00);
                chk("turn_ie", bidir_ie, 32'h00);
                chk("turn_ready", tx_ready, 32'h0);
                chk("turn_busy", busy, 32'h1);
            end else if (c <= 16) begin
                chk("settle_oe", bidir_oe, 32'h00);
                chk("settle_ie", bidir_ie, 32'hFF);
                chk("settle_ready", tx_ready, 32'h0);
                chk("settle_busy", busy, 32'h1);
            end else begin
                chk("burst_idle_ready", tx_ready, 32'h1);
                chk("burst_idle_busy", busy, 32'h0);
            end
            if (c == 1) begin
                tx_data = words[1];
            end else if (c == 5) begin
                tx_data = words[2];
                tx_last = 1'b1;
            end else if (c == 9) begin
                tx_valid = 1'b0;
                tx_last  = 1'b0;
            end
        end
        tick();
        chk("no_spurious_rx", rx_valid, 32'h0);
`ifdef BIDIR_PAD_CTRL_READBACK_EN
        chk("burst_derr", drive_err, 32'h1);
`endif

        // hold 0 behaves as 1
        cfg_hold = 8'd0;
        tx_data  = 8'hFF;
        tx_last  = 1'b1;
        tx_valid = 1'b1;
        tick();
        chk("h0_out", bidir_out, 32'hFF);
        chk("h0_oe", bidir_oe, 32'hFF);
        chk("h0_ready", tx_ready, 32'h0);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tick();
        chk("h0_oe_off", bidir_oe, 32'h00);
        chk("h0_out_off", bidir_out, 32'h00);
        tick();
        tick();
        tick();
        chk("h0_c5_ready", tx_ready, 32'h0);
        tick();
        chk("h0_c6_ready", tx_ready, 32'h1);
        chk("h0_c6_busy", busy, 32'h0);

        // underrun: H=2, next word offered only after 5 idle ready cycles
        cfg_hold = 8'd2;
        tx_data  = 8'hA1;
        tx_last  = 1'b0;
        tx_valid = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk("ur_out", bidir_out, (c <= 7) ? 32'hA1 : 32'hB2);
            chk("ur_oe", bidir_oe, 32'hFF);
            chk("ur_ready", tx_ready, (c >= 2 && c <= 7) ? 32'h1 : 32'h0);
            if (c == 1) begin
                tx_valid = 1'b0;
            end else if (c == 7) begin
                tx_valid = 1'b1;
                tx_data  = 8'hB2;
                tx_last  = 1'b1;
            end else if (c == 8) begin
                tx_valid = 1'b0;
                tx_last  = 1'b0;
            end
        end
        tick();
        chk("ur_oe_off", bidir_oe, 32'h00);
        tick();
        tick();
        tick();
        tick();
        chk("ur_idle_ready", tx_ready, 32'h1);

        // asynchronous reset in the middle of a word
        cfg_hold = 8'd8;
        tx_data  = 8'h77;
        tx_last  = 1'b1;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tick();
        tick();
        chk("mid_oe", bidir_oe, 32'hFF);
        chk("mid_busy", busy, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_oe", bidir_oe, 32'h00);
        chk("arst_out", bidir_out, 32'h00);
        chk("arst_ie", bidir_ie, 32'hFF);
        chk("arst_ready", tx_ready, 32'h0);
        chk("arst_busy", busy, 32'h0);
        chk("arst_cs", bidir_cs, 32'h00);
        chk("arst_rxd", rx_data, 32'h00);
`ifdef BIDIR_PAD_CTRL_READBACK_EN
        chk("arst_derr", drive_err, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arel_ready", tx_ready, 32'h1);
        chk("arel_busy", busy, 32'h0);
        chk("arel_oe", bidir_oe, 32'h00);
        chk("arel_cs", bidir_cs, 32'hA5);

`ifdef BIDIR_PAD_CTRL_READBACK_EN
        // matching readback leaves drive_err clear
        bidir_in = 8'h0F;
        repeat (5) tick();
        cfg_hold = 8'd4;
        tx_data  = 8'h0F;
        tx_last  = 1'b1;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        repeat (8) tick();
        chk("rb_match_busy", busy, 32'h0);
        chk("rb_match_derr", drive_err, 32'h0);

        // pad held low while driving 0x0F sets the sticky error
        bidir_in = 8'h00;
        repeat (5) tick();
        tx_data  = 8'h0F;
        tx_last  = 1'b1;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        repeat (8) tick();
        chk("rb_mismatch_derr", drive_err, 32'h1);
        repeat (5) tick();
        chk("rb_sticky_derr", drive_err, 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bidir_pad_ctrl.md
# bidir_pad_ctrl

Core-side driver for the `gf180mcu_fd_io__bi_24t` bidirectional pad bank. It is the core-to-pad counterpart of the pad ring's `bidir_PAD2CORE` input path.
- Accepts words from core logic over a valid/ready handshake and drives them onto the pads for a programmable hold time.
- Handles output-enable turnaround so the core never fights an external driver.
- Synchronises `bidir_in` and reports changes while the bus is released.
- Generates the static CS/SL/PU/PD controls.

Instantiated in `chip_core` between core logic and the `bidir_CORE2PAD_*` / `bidir_PAD2CORE` nets.

## Interface
Parameters:
- `NUM_BIDIR_PADS`, default `` `NUM_BIDIR_PADS ``: pad count (N).
- `HOLD_W`, default 8: width of per-word hold count.
- `TURN_CYCLES`, default 2: released-bus guard cycles after the last word.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_valid` in 1, `tx_ready` out 1, `tx_data` in N, `tx_last` in 1: word handshake. `tx_last` releases the bus after this word.
- `cfg_hold`  in  HOLD_W  cycles each word is held. Sampled at word accept; 0 behaves as 1.
- `cfg_cs`, `cfg_sl`, `cfg_pu`, `cfg_pd`  in  N each  static pad controls.
- `rx_valid`  out  1  one-cycle pulse: released-bus pad value changed.
- `rx_data`  out  N  last synchronised released-bus pad value.
- `busy`  out  1  high in any state other than IDLE.
- `bidir_in`  in  N  from pad Y.
- `bidir_out`, `bidir_oe`, `bidir_ie`, `bidir_cs`, `bidir_sl`, `bidir_pu`, `bidir_pd`  out  N each  to pad A/OE/IE/CS/SL/PU/PD.

## Operation
States:
- **IDLE**
  - Outputs: `oe`=0, `ie`=1, `out`=0.
  - `tx_ready`=1.
  - On accept, latch `tx_data`, `tx_last` and H = max(`cfg_hold`, 1), then go to DRIVE.
- **DRIVE**
  - Outputs: `oe`=all 1, `ie`=0, `out`=latched word.
  - Hold counter counts H cycles.
  - `tx_ready`=1 only in the last hold cycle of a non-last word. An accept there loads the next word with no gap.
  - No `tx_valid` in the last hold cycle (underrun): keep driving the current word, keep `tx_ready`=1, and accept on the first valid.
  - Last hold cycle of a `tx_last` word: go to TURN_OFF.
- **TURN_OFF**
  - Outputs: `oe`=0, `ie`=0, `out`=0 for `TURN_CYCLES` cycles.
  - `tx_ready`=0.
  - Then go to SETTLE.
- **SETTLE**
  - Outputs: `oe`=0, `ie`=1 for 2 cycles.
  - `tx_ready`=0.
  - Then go to IDLE.

Rx path:
- `bidir_in` passes through a 2-flop synchroniser.
- In IDLE, a synchronised value different from `rx_data` loads `rx_data` and pulses `rx_valid` for one cycle.
- In DRIVE, TURN_OFF and SETTLE, `rx_data` tracks the synchroniser silently and `rx_valid`=0. No spurious event follows bus release.

Static controls:
- `cfg_cs`/`cfg_sl`/`cfg_pu`/`cfg_pd` are registered to the `bidir_*` outputs with 1-cycle latency.
- Any bit with both PU and PD set drives `bidir_pd`=0 (pull-up wins).

Reset (asynchronous): every output reaches its reset value immediately, including mid-DRIVE.
- `bidir_oe`=0, `bidir_out`=0, `bidir_ie`=all 1.
- `bidir_cs`, `bidir_sl`, `bidir_pu`, `bidir_pd`=0.
- `tx_ready`=0 during reset, 1 from the first cycle after release.
- `rx_valid`=0, `rx_data`=0, `busy`=0.
- State IDLE.

## Timing
- Word accepted at edge T appears on `bidir_out`/`bidir_oe` from cycle T+1 and is held through cycle T+H.
- Back-to-back words have zero bubble.
- After the last word, `oe`=0 from cycle T+H+1.
- IDLE is re-entered and `tx_ready` rises at T+H+TURN_CYCLES+3.
- Rx: a pad change in IDLE produces `rx_valid` 3 edges later.
- All pad-facing outputs are registered, with no combinational path from `tx_*`.

## Configuration
- `BIDIR_PAD_CTRL_READBACK_EN` defined:
  - Adds output `drive_err` (1 bit, sticky, reset 0).
  - In the last hold cycle of every word with H≥3, the synchronised `bidir_in` is compared with the driven word. A mismatch sets `drive_err`.
  - `drive_err` clears only on reset.
- Undefined: no port, no comparator.

## Structure
- `bidir_pad_pkg` contents:
  - state enum (IDLE, DRIVE, TURN_OFF, SETTLE);
  - `SETTLE_CYCLES`=2;
  - `SYNC_STAGES`=2.
- Sub-module `bidir_in_sync`: an N-wide 2-flop synchroniser with async active-low reset to 0.

## Test plan
- Reset release, no traffic → `oe`=0, `ie`=all 1, `tx_ready`=1, `busy`=0; `bidir_in` 0→0x5A → one `rx_valid`, `rx_data`=0x5A, 3 cycles after the change.
- Words 0x11, 0x22, 0x33 (last) with `cfg_hold`=4 and `tx_valid` held high → 0x11 for 4 cycles, then 0x22, then 0x33, no gaps. `oe`=0 on cycle 13. `tx_ready` returns 2+3 cycles later.
- `cfg_hold`=0, single last word 0xFF → driven exactly 1 cycle.
- Underrun: `tx_valid` dropped for 5 cycles after the first word (H=2) → word held for 7 cycles, `oe` never drops.
- `rst_n` asserted mid-DRIVE → `bidir_oe`=0 immediately; first cycle after release: IDLE, `tx_ready`=1.
- With READBACK_EN, H=4, `bidir_in` forced to 0x00 while driving 0x0F → `drive_err`=1, stays set until reset.
